dmem_sp_bridge: RTL and testbench

//   Memory-side responder for the core's dual-port data-memory request interface (per-port we/addr/wdata/is48).

---
 rtl/dmem_sp_bridge.sv | 138 +++++++++++++
 tb/tb_dmem_sp_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sp_bridge.sv
// Single-port SRAM responder for the core's dual-port data-memory interface.
// Arbitrates the two ports and splits 48-bit accesses into lo/hi 24-bit SRAM cycles.
module dmem_sp_bridge #(
  parameter int ADDR_W = 12,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req0,
  input  logic              iw_we0,
  input  logic              iw_is48_0,
  input  logic [47:0]       iw_addr0,
  input  logic [47:0]       iw_wdata0,
  input  logic              iw_req1,
  input  logic              iw_we1,
  input  logic              iw_is48_1,
  input  logic [47:0]       iw_addr1,
  input  logic [47:0]       iw_wdata1,
  output logic              or_ack0,
  output logic [47:0]       or_rdata0,
  output logic              or_ack1,
  output logic [47:0]       or_rdata1,
  output logic              ow_busy,
  output logic              ow_sram_en,
  output logic              ow_sram_we,
  output logic [ADDR_W-1:0] ow_sram_addr,
  output logic [23:0]       ow_sram_wdata,
  input  logic [23:0]       iw_sram_rdata
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t              state, state_nxt;
  logic                cur_port, cur_we, cur_is48;
  logic [ADDR_W-1:0]   cur_addr;
  logic [47:0]         cur_wdata;
  logic [23:0]         lo_word;
  logic                last_grant;
  logic [1:0]          eligible;
  logic                grant_port;
  logic [47:0]         result;

  // Core addresses are wider than the SRAM; the upper bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{iw_addr0[47:ADDR_W], iw_addr1[47:ADDR_W]};

  // A port is masked in its own ack cycle, so a held req is not served twice.
  assign eligible = {iw_req1 & ~or_ack1, iw_req0 & ~or_ack0};
  assign ow_busy  = (state != IDLE);
  assign result   = cur_is48 ? {iw_sram_rdata, lo_word} : {24'h0, iw_sram_rdata};

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
    grant_port = 1'b0;
    if (eligible == 2'b10)      grant_port = 1'b1;
    else if (eligible == 2'b11) grant_port = RR_EN ? ~last_grant : 1'b0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (|eligible) state_nxt = LO;
      LO:   state_nxt = cur_is48 ? HI : FIN;
      HI:   state_nxt = FIN;
      FIN:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ow_sram_en    = 1'b0;
    ow_sram_we    = 1'b0;
    ow_sram_addr  = cur_addr;
    ow_sram_wdata = cur_wdata[23:0];
    unique case (state)
      LO: begin
        ow_sram_en = 1'b1;
        ow_sram_we = cur_we;
      end
      HI: begin
        ow_sram_en    = 1'b1;
        ow_sram_we    = cur_we;
        ow_sram_addr  = cur_addr + 1'b1;
        ow_sram_wdata = cur_wdata[47:24];
      end
      default: ;
    endcase
    // Reset aborts at once: the in-flight SRAM cycle must not land.
    if (iw_rst) begin
      ow_sram_en = 1'b0;
      ow_sram_we = 1'b0;
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state      <= IDLE;
      or_ack0    <= 1'b0;
      or_ack1    <= 1'b0;
      or_rdata0  <= '0;
      or_rdata1  <= '0;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      cur_is48   <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      lo_word    <= '0;
    end else begin
      state   <= state_nxt;
      or_ack0 <= 1'b0;
      or_ack1 <= 1'b0;
      unique case (state)
        IDLE: if (|eligible) begin
          cur_port   <= grant_port;
          last_grant <= grant_port;
          cur_we     <= grant_port ? iw_we1 : iw_we0;
          cur_is48   <= grant_port ? iw_is48_1 : iw_is48_0;
          cur_addr   <= grant_port ? iw_addr1[ADDR_W-1:0] : iw_addr0[ADDR_W-1:0];
          cur_wdata  <= grant_port ? iw_wdata1 : iw_wdata0;
        end
        LO: ;
        // Read data of the LO cycle arrives here.
        HI: if (!cur_we) lo_word <= iw_sram_rdata;
        FIN: begin
          if (cur_port) begin
            or_ack1 <= 1'b1;
            if (!cur_we) or_rdata1 <= result;
          end else begin
            or_ack0 <= 1'b1;
            if (!cur_we) or_rdata0 <= result;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sp_bridge.sv
// Bench for dmem_sp_bridge: per-port command driver, SRAM model, and a scoreboard
// fed from an abstract word-array reference model.
module tb_dmem_sp_bridge;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic        we;
    logic        is48;
    logic [47:0] addr;
    logic [47:0] wdata;
    int          gap;
    bit          chk_lat;
  } cmd_t;
  typedef struct { int port; int cyc; } ack_ev_t;
  typedef struct { bit we; int addr; } en_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        req[2], we[2], is48[2];
  logic [47:0] addr[2], wdata[2];
  logic        ack_w[2];
  logic [47:0] rdata_w[2];
  logic              busy, sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [23:0]       sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  cmd_t        cmd_q[2][$];
  logic [47:0] exp_q[2][$];
  ack_ev_t     ack_log[$];
  en_ev_t      en_log[$];
  logic [23:0] ref_mem[DEPTH];
  logic [47:0] last_rd[2];
  logic [23:0] sram[DEPTH];
  bit          loaded = 1'b0;

  bit   active[2], pending[2];
  int   gap_cnt[2], wait_cnt[2];
  cmd_t cur[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sp_bridge #(.ADDR_W(ADDR_W), .RR_EN(1'b1)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_req0(req[0]), .iw_we0(we[0]), .iw_is48_0(is48[0]), .iw_addr0(addr[0]), .iw_wdata0(wdata[0]),
    .iw_req1(req[1]), .iw_we1(we[1]), .iw_is48_1(is48[1]), .iw_addr1(addr[1]), .iw_wdata1(wdata[1]),
    .or_ack0(ack_w[0]), .or_rdata0(rdata_w[0]), .or_ack1(ack_w[1]), .or_rdata1(rdata_w[1]),
    .ow_busy(busy), .ow_sram_en(sram_en), .ow_sram_we(sram_we), .ow_sram_addr(sram_addr),
    .ow_sram_wdata(sram_wdata), .iw_sram_rdata(sram_rdata)
  );

  function automatic logic [23:0] init_val(input int i);
    return 24'((i * 40503) ^ 32'h5A5A5A);
  endfunction

  function automatic cmd_t mk(input logic w, input logic l, input logic [47:0] a,
                              input logic [47:0] d, input int g, input bit lat);
    cmd_t c;
    c.we = w; c.is48 = l; c.addr = a; c.wdata = d; c.gap = g; c.chk_lat = lat;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Single-port synchronous SRAM: read data appears the cycle after an en&!we cycle.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) sram[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram[sram_addr];
      en_log.push_back('{sram_we, int'(sram_addr)});
    end
  end

  // Reference model: memory is a flat array of 24-bit words, 48-bit = {mem[a+1], mem[a]}.
  task automatic issue(input int p, input cmd_t c);
    logic [ADDR_W-1:0] a, a1;
    logic [47:0]       e;
    a  = c.addr[ADDR_W-1:0];
    a1 = a + 1'b1;
    we[p] = c.we; is48[p] = c.is48; addr[p] = c.addr; wdata[p] = c.wdata; req[p] = 1'b1;
    if (c.we) begin
      ref_mem[a] = c.wdata[23:0];
      if (c.is48) ref_mem[a1] = c.wdata[47:24];
      e = last_rd[p];
    end else begin
      e = c.is48 ? {ref_mem[a1], ref_mem[a]} : {24'h0, ref_mem[a]};
      last_rd[p] = e;
    end
    exp_q[p].push_back(e);
  endtask

  // Driver: one request per port at a time, req held until ack, next command may follow at once.
  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; is48[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
      active[p] = 1'b0; pending[p] = 1'b0; gap_cnt[p] = 0; wait_cnt[p] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          active[p] = 1'b0; pending[p] = 1'b0; req[p] = 1'b0;
        end else begin
          if (active[p]) begin
            wait_cnt[p]++;
            if (ack_w[p]) begin
              active[p] = 1'b0;
              if (cur[p].chk_lat)
                check($sformatf("latency_port%0d", p), wait_cnt[p], cur[p].is48 ? 4 : 3);
            end else if (wait_cnt[p] > 60) begin
              fail_now($sformatf("ack_timeout_port%0d", p));
              exp_q[p].delete();
              active[p] = 1'b0;
            end
          end
          if (!active[p]) begin
            if (!pending[p] && cmd_q[p].size() > 0) begin
              cur[p] = cmd_q[p].pop_front();
              pending[p] = 1'b1;
              gap_cnt[p] = cur[p].gap;
            end
            if (pending[p] && gap_cnt[p] == 0) begin
              issue(p, cur[p]);
              pending[p] = 1'b0; active[p] = 1'b1; wait_cnt[p] = 0;
            end else begin
              req[p] = 1'b0;
              if (pending[p]) gap_cnt[p]--;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the expected response whenever a port acks.
  initial begin
    logic prev_ack[2];
    prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q[0].delete(); exp_q[1].delete();
        prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
      end else begin
        if (ack_w[0] && ack_w[1]) fail_now("both_acks_high");
        for (int p = 0; p < 2; p++) begin
          if (ack_w[p]) begin
            if (prev_ack[p]) fail_now($sformatf("ack%0d_pulse_width", p));
            if (exp_q[p].size() == 0) fail_now($sformatf("ack%0d_spurious", p));
            else check($sformatf("rdata%0d", p), rdata_w[p], exp_q[p].pop_front());
            ack_log.push_back('{p, cyc});
          end
          prev_ack[p] = ack_w[p];
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((cmd_q[0].size() > 0 || cmd_q[1].size() > 0 || active[0] || active[1] ||
            pending[0] || pending[1]) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int bad;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_sram_en", sram_en, 0);
    check("rst_ack0", ack_w[0], 0);
    check("rst_ack1", ack_w[1], 0);
    check("rst_rdata0", rdata_w[0], 0);
    check("rst_rdata1", rdata_w[1], 0);
    rst = 1'b0;

    // 48-bit write on port 1, then 48-bit read back on port 0.
    cmd_q[1].push_back(mk(1'b1, 1'b1, 48'd20, 48'hCAFEBE_987654, 0, 1'b1));
    wait_idle();
    check("t1_sram20", sram[20], 24'h987654);
    check("t1_sram21", sram[21], 24'hCAFEBE);

    en_log.delete();
    cmd_q[0].push_back(mk(1'b0, 1'b1, 48'd20, 48'h0, 0, 1'b1));
    wait_idle();
    check("t2_en_cycles", en_log.size(), 2);
    if (en_log.size() == 2) begin
      check("t2_addr_lo", en_log[0].addr, 20);
      check("t2_addr_hi", en_log[1].addr, 21);
      check("t2_we_lo", en_log[0].we, 0);
      check("t2_we_hi", en_log[1].we, 0);
    end
    check("t2_rdata0", rdata_w[0], 48'hCAFEBE_987654);

    // 24-bit read, then a 24-bit write carrying junk upper data/address bits.
    cmd_q[0].push_back(mk(1'b0, 1'b0, 48'd21, 48'h0, 0, 1'b1));
    wait_idle();
    check("t3_rdata0", rdata_w[0], 48'h000000_CAFEBE);
    en_log.delete();
    cmd_q[1].push_back(mk(1'b1, 1'b0, 48'hABC0_0000_0005, 48'hFFFFFF_123456, 0, 1'b1));
    wait_idle();
    check("t3_en_cycles", en_log.size(), 1);
    check("t3_sram5", sram[5], 24'h123456);
    check("t3_sram4", sram[4], init_val(4));
    check("t3_sram6", sram[6], init_val(6));

    // Address wrap at the top of the SRAM.
    cmd_q[0].push_back(mk(1'b1, 1'b1, 48'(DEPTH - 1), 48'hAAAAAA_555555, 0, 1'b1));
    wait_idle();
    check("t5_sram_max", sram[DEPTH-1], 24'h555555);
    check("t5_sram0", sram[0], 24'hAAAAAA);
    cmd_q[1].push_back(mk(1'b0, 1'b1, 48'(DEPTH - 1), 48'h0, 0, 1'b1));
    wait_idle();
    check("t5_rdata1", rdata_w[1], 48'hAAAAAA_555555);

    // Reset while the hi word of a 48-bit write is on the SRAM bus.
    cmd_q[0].push_back(mk(1'b1, 1'b1, 48'd100, 48'h777777_888888, 0, 1'b0));
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (sram_en && sram_we && sram_addr == 12'd101) found = 1'b1;
    end
    if (!found) fail_now("t6_hi_cycle_not_seen");
    rst = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk); #2;
    check("t6_busy", busy, 0);
    check("t6_sram_en", sram_en, 0);
    check("t6_ack0", ack_w[0], 0);
    check("t6_rdata0", rdata_w[0], 0);
    check("t6_rdata1", rdata_w[1], 0);
    @(posedge clk); #2;
    rst = 1'b0;
    ref_mem[101] = init_val(101);
    check("t6_sram100", sram[100], 24'h888888);
    check("t6_sram101", sram[101], init_val(101));

    // Both ports held busy from the same cycle: strict alternation starting at port 0.
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_q[0].push_back(mk(1'(i % 2 == 0), 1'b0, 48'(200 + i), 48'(32'h100000 + i), 0, 1'b0));
      cmd_q[1].push_back(mk(1'(i % 2 == 0), 1'b0, 48'(2200 + i), 48'(32'h200000 + i), 0, 1'b0));
    end
    wait_idle();
    check("t4_ack_count", ack_log.size(), 8);
    for (int k = 0; k < ack_log.size(); k++) begin
      check($sformatf("t4_grant%0d_port", k), ack_log[k].port, k % 2);
      if (k > 0) check($sformatf("t4_gap%0d", k), ack_log[k].cyc - ack_log[k-1].cyc, 3);
    end

    // Random traffic, each port in its own address region.
    for (int i = 0; i < 120; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [47:0] a, d;
        a[47:32] = 16'($urandom());
        a[31:0]  = $urandom();
        a[ADDR_W-1:0] = ADDR_W'((p == 0 ? 1024 : 3072) + $urandom_range(0, 1022));
        d[47:32] = 16'($urandom());
        d[31:0]  = $urandom();
        cmd_q[p].push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
                              $urandom_range(0, 3), 1'b0));
      end
    end
    wait_idle();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    check("mem_sweep_mismatches", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
